// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width codes, opcode constants and the store-lane/legality rules.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ISSUE,
        LSU_WAIT_R,
        LSU_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic lsu_f3_illegal(input logic is_ld, input logic [2:0] f3);
        if (is_ld) begin
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        end
        return (f3 > F3_W);
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd1:    return addr_lo[0];
            2'd2:    return (addr_lo != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_store_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    return 4'b0001 << addr_lo;
            2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            2'd0:    return {4{rs2[7:0]}};
            2'd1:    return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load-path lane select and sign/zero extension of a memory word.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: address generation, alignment checks and a
// req/gnt + rvalid handshake to a word-addressed data memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state, state_n;
    logic              load_q, load_n;
    logic [2:0]        f3_q, f3_n;
    logic [1:0]        addr_lo_q, addr_lo_n;
    logic              done_n, err_n, mem_req_n, mem_we_n;
    logic [DATA_W-1:0] rdata_n, mem_wdata_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [3:0]        mem_wmask_n;
    logic [DATA_W-1:0] byte_addr;
    logic [DATA_W-1:0] load_result;
    logic              unused_addr_hi;

    // Word address wraps silently: bits above the memory range are dropped.
    assign byte_addr      = rs1_data + imm;
    assign unused_addr_hi = ^byte_addr[DATA_W-1:ADDR_W+2];
    assign req_ready      = (state == LSU_IDLE);

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (f3_q),
        .result    (load_result)
    );

    always_comb begin
        state_n     = state;
        load_n      = load_q;
        f3_n        = f3_q;
        addr_lo_n   = addr_lo_q;
        done_n      = 1'b0;
        err_n       = err;
        rdata_n     = rdata;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wmask_n = mem_wmask;
        mem_wdata_n = mem_wdata;

        case (state)
            LSU_IDLE: begin
                err_n = 1'b0;
                if (req_valid && (is_load || is_store)) begin
                    load_n    = is_load;
                    f3_n      = funct3;
                    addr_lo_n = byte_addr[1:0];
                    if (lsu_f3_illegal(is_load, funct3) ||
                        lsu_misaligned(funct3[1:0], byte_addr[1:0])) begin
                        state_n = LSU_RESP;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n     = LSU_ISSUE;
                        mem_req_n   = 1'b1;
                        mem_we_n    = !is_load;
                        mem_addr_n  = byte_addr[ADDR_W+1:2];
                        mem_wmask_n = is_load ? 4'b0000 : lsu_store_mask(funct3[1:0], byte_addr[1:0]);
                        mem_wdata_n = is_load ? '0 : lsu_store_data(funct3[1:0], rs2_data);
                    end
                end
            end
            LSU_ISSUE: begin
                if (mem_gnt) begin
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (load_q) begin
                        state_n = LSU_WAIT_R;
                    end else begin
                        state_n = LSU_RESP;
                        done_n  = 1'b1;
                    end
                end
            end
            LSU_WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_n = load_result;
                    state_n = LSU_RESP;
                    done_n  = 1'b1;
                end
            end
            LSU_RESP: begin
                state_n = LSU_IDLE;
                err_n   = 1'b0;
            end
            default: state_n = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LSU_IDLE;
            load_q    <= 1'b0;
            f3_q      <= 3'd0;
            addr_lo_q <= 2'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            load_q    <= load_n;
            f3_q      <= f3_n;
            addr_lo_q <= addr_lo_n;
            done      <= done_n;
            err       <= err_n;
            rdata     <= rdata_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wmask <= mem_wmask_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the core's EXECUTE state.
- Takes decoded LOAD/STORE operands from the core (rs1_data, rs2_data, sign-extended immediate, funct3).
- Computes the byte address, checks alignment, and drives a word-addressed data memory through a req/gnt + rvalid handshake.
- Returns sign- or zero-extended load data with a one-cycle done pulse.
- The core holds in EXECUTE until done.

Parameters:
- ADDR_W, 8, width of the word address into data memory (256 words).
- DATA_W, 32, data width; fixed at 32, and other values are unsupported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core requests an access; held high until done.
- req_ready  out  1  LSU is in IDLE and can accept a request.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV32I width/sign code.
- rs1_data  in  32  base register value.
- rs2_data  in  32  store data.
- imm  in  32  sign-extended imm_i (load) or imm_s (store).
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1 and is_load.
- err  out  1  misaligned access or illegal funct3; valid with done.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2].
- mem_wmask  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid (one cycle after gnt or later).
- mem_rdata  in  32  read word.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wmask, mem_wdata = 0. All outputs are registered, except req_ready = (state==IDLE).
- Address arithmetic: byte_addr = rs1_data + imm, modulo 2^32. Bits above ADDR_W+1 are ignored, so the word address wraps silently.

State machine: IDLE, ISSUE, WAIT_R, RESP.
- IDLE, when req_valid && (is_load || is_store):
  - Latch operands and compute byte_addr.
  - If misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or funct3 is illegal (load 3/6/7; store >=3): go to RESP with err=1. No memory access occurs.
  - Otherwise go to ISSUE with mem_req=1 and mem_addr/we/wmask/wdata set.
- IDLE with req_valid but neither is_load nor is_store: ignored; stay in IDLE.
- ISSUE: mem_req and all mem_* outputs are held stable until mem_gnt.
  - On gnt, mem_req drops next cycle.
  - Store goes to RESP; load goes to WAIT_R.
- WAIT_R: wait for mem_rvalid.
  - On rvalid: select the lane by addr[1:0] and extend per funct3 (LB/LH sign, LBU/LHU zero, LW whole word).
  - Register the result into rdata and go to RESP.
- RESP: done=1 for exactly one cycle, with err as latched; then go to IDLE. rdata holds its value until the next load completes.

Store lane rules:
- SB: wmask = 1<<addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: wmask = 0011 or 1100; wdata = {2{rs2[15:0]}}.
- SW: wmask = 1111.

Latency, with request accepted at cycle 0 and gnt given combinationally with req:
- Store: mem_req in cycle 1, done in cycle 2.
- Load with rvalid in cycle 2: done in cycle 3.
- Error: done in cycle 1.

Boundary conditions:
- mem_rvalid outside WAIT_R is ignored.
- mem_gnt outside ISSUE is ignored.
- If both is_load and is_store are set, the load takes priority.
- Reset mid-transaction aborts it immediately: mem_req drops asynchronously and no done is issued.
- A back-to-back request is accepted in the cycle after done, when the FSM is back in IDLE.

Decomposition:
- Add to def.sv:
  - lsu_state_t enum {LSU_IDLE, LSU_ISSUE, LSU_WAIT_R, LSU_RESP}.
  - funct3 localparams F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - Opcode constants LOAD=7'b0000011 and STORE=7'b0100011, shared with the core decoder.
- One sub-module, lsu_load_align: a combinational lane select plus sign/zero extend, taking (mem_rdata, addr[1:0], funct3) and producing the 32-bit result. It is unit-testable on its own.

Test Plan:
1. SW: rs1=0x10, imm=4, rs2=0xDEADBEEF, gnt same cycle -> mem_addr=5, wmask=1111, wdata=0xDEADBEEF, mem_we=1; done in cycle 2, err=0.
2. LB, LBU: rs1=0x13, imm=0, rdata word 0x80FF_7F01.
   - LB -> lane 3, rdata=0xFFFFFF80.
   - LBU -> rdata=0x00000080.
3. SH: addr=0x2, rs2=0x1234ABCD -> wmask=1100, wdata=0xABCDABCD.
4. LW: addr=0x6 -> no mem_req; done in cycle 1 with err=1.
5. LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> mem_req and mem_addr are stable while waiting, mem_req drops after gnt, exactly one done pulse with rdata = mem_rdata.
6. Reset asserted while in WAIT_R -> mem_req=0, no done, req_ready=1 after release; a late rvalid is ignored.
